// File: rtl/klein_pkg.sv
// klein_pkg
//   Shared definitions for the KLEIN stream sequencer: datapath widths and
//   the sequencer state encoding.
package klein_pkg;

  localparam int KLEIN_BLOCK_W = 64;
  localparam int KLEIN_KEY_W   = 64;

  typedef enum logic [2:0] {
    ST_NOKEY      = 3'd0,
    ST_INIT_PULSE = 3'd1,
    ST_INIT_WAIT  = 3'd2,
    ST_READY      = 3'd3,
    ST_NEXT_PULSE = 3'd4,
    ST_NEXT_WAIT  = 3'd5
  } state_t;

endpackage : klein_pkg

// File: rtl/klein_wait_timer.sv
// klein_wait_timer
//   Counts cycles spent waiting for the KLEIN core after an init/next pulse.
//   The count holds 1 in the first wait cycle and k in the k-th wait cycle,
//   so the expire flag raised on count TIMEOUT_CYCLES-1 lands the registered
//   error exactly TIMEOUT_CYCLES cycles after the pulse. TIMEOUT_CYCLES must
//   be at least 2.
//
// Ports
//   iclk      clock
//   ireset_n  asynchronous active-low reset
//   iload     restart the count (asserted during the pulse cycle)
//   irun      count while the sequencer waits on the core
//   ofirst    first wait cycle, when the core's ready is not yet meaningful
//   oexpire   wait budget used up
module klein_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic iclk,
  input  logic ireset_n,
  input  logic iload,
  input  logic irun,
  output logic ofirst,
  output logic oexpire
);

  localparam int           W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement or process order.
  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      cnt_q <= '0;
    end else if (iload) begin
      cnt_q <= W'(1);
    end else if (irun && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign ofirst  = irun && (cnt_q == W'(1));
  assign oexpire = irun && (cnt_q == LAST);

endmodule : klein_wait_timer

// File: rtl/klein_stream_ctrl.sv
// klein_stream_ctrl
//   Initiator-side sequencer for a KLEIN cipher core. Takes keys and 64-bit
//   blocks from a valid/ready stream, runs the key-schedule init before any
//   block, pulses next per block while holding key/block/direction stable,
//   and returns results on a one-deep valid/ready output.
//
// Ports
//   iclk, ireset_n                       clock, async active-low reset
//   ikey_load, ikey                      key load request and key value
//   iin_valid, iin_data, iin_encdec      input block stream (1=encipher)
//   oin_ready                            input handshake
//   oout_valid, oout_data, iout_ready    result stream
//   ocore_init, ocore_next               one-cycle pulses to the core
//   ocore_encdec, ocore_key, ocore_block registered operands to the core
//   icore_ready, icore_result_valid      core status
//   icore_block                          core result
//   okey_valid                           key schedule complete
//   oerr                                 sticky wait timeout
//   ocount                               blocks completed since key load
module klein_stream_ctrl
  import klein_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic                     iclk,
  input  logic                     ireset_n,
  input  logic                     ikey_load,
  input  logic [0:KLEIN_KEY_W-1]   ikey,
  input  logic                     iin_valid,
  input  logic [0:KLEIN_BLOCK_W-1] iin_data,
  input  logic                     iin_encdec,
  output logic                     oin_ready,
  output logic                     oout_valid,
  output logic [0:KLEIN_BLOCK_W-1] oout_data,
  input  logic                     iout_ready,
  output logic                     ocore_init,
  output logic                     ocore_next,
  output logic                     ocore_encdec,
  output logic [0:KLEIN_KEY_W-1]   ocore_key,
  output logic [0:KLEIN_BLOCK_W-1] ocore_block,
  input  logic                     icore_ready,
  input  logic                     icore_result_valid,
  input  logic [0:KLEIN_BLOCK_W-1] icore_block,
  output logic                     okey_valid,
  output logic                     oerr,
  output logic [CNT_W-1:0]         ocount
);

  state_t                   state_q, state_d;
  logic                     key_pending_q;
  logic [0:KLEIN_KEY_W-1]   pend_key_q;
  logic [0:KLEIN_KEY_W-1]   key_src;

  logic accept;
  logic timer_first, timer_expire;
  logic load_key, stash_key, set_key_valid, set_err, block_done;

  // Output is one-deep: a new block may enter only if the held result is
  // empty or drains this same cycle. A pending key blocks input so the new
  // schedule runs before any further block.
  assign oin_ready = (state_q == ST_READY) && !key_pending_q &&
                     (!oout_valid || iout_ready);
  assign accept    = iin_valid && oin_ready;

  assign ocore_init = (state_q == ST_INIT_PULSE);
  assign ocore_next = (state_q == ST_NEXT_PULSE);

  // A fresh load takes precedence over an older pending key.
  assign key_src = ikey_load ? ikey : pend_key_q;

  klein_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .iclk    (iclk),
    .ireset_n(ireset_n),
    .iload   ((state_q == ST_INIT_PULSE) || (state_q == ST_NEXT_PULSE)),
    .irun    ((state_q == ST_INIT_WAIT)  || (state_q == ST_NEXT_WAIT)),
    .ofirst  (timer_first),
    .oexpire (timer_expire)
  );

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q <= ST_NOKEY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    load_key      = 1'b0;
    stash_key     = 1'b0;
    set_key_valid = 1'b0;
    set_err       = 1'b0;
    block_done    = 1'b0;

    unique case (state_q)
      ST_NOKEY: begin
        if (ikey_load) begin
          load_key = 1'b1;
          state_d  = ST_INIT_PULSE;
        end
      end

      ST_INIT_PULSE: begin
        stash_key = ikey_load;
        state_d   = ST_INIT_WAIT;
      end

      // The core drops ready one cycle after a pulse, so the first wait
      // cycle still shows the stale idle level.
      ST_INIT_WAIT: begin
        stash_key = ikey_load;
        if (!timer_first && icore_ready) begin
          set_key_valid = 1'b1;
          state_d       = ST_READY;
        end else if (timer_expire) begin
          set_err = 1'b1;
          state_d = ST_NOKEY;
        end
      end

      // An accept beats a simultaneous key load; the key then waits.
      ST_READY: begin
        if (accept) begin
          stash_key = ikey_load;
          state_d   = ST_NEXT_PULSE;
        end else if (ikey_load || key_pending_q) begin
          load_key = 1'b1;
          state_d  = ST_INIT_PULSE;
        end
      end

      ST_NEXT_PULSE: begin
        stash_key = ikey_load;
        state_d   = ST_NEXT_WAIT;
      end

      ST_NEXT_WAIT: begin
        stash_key = ikey_load;
        if (!timer_first && icore_ready && icore_result_valid) begin
          block_done = 1'b1;
          state_d    = ST_READY;
        end else if (timer_expire) begin
          set_err = 1'b1;
          state_d = ST_NOKEY;
        end
      end

      default: state_d = ST_NOKEY;
    endcase
  end

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      ocore_key     <= '0;
      ocore_block   <= '0;
      ocore_encdec  <= 1'b1;
      pend_key_q    <= '0;
      key_pending_q <= 1'b0;
      okey_valid    <= 1'b0;
      oerr          <= 1'b0;
      ocount        <= '0;
      oout_valid    <= 1'b0;
      oout_data     <= '0;
    end else begin
      if (load_key) begin
        ocore_key     <= key_src;
        key_pending_q <= 1'b0;
        okey_valid    <= 1'b0;
        oerr          <= 1'b0;
        ocount        <= '0;
      end

      // Operands are only written on load/accept, which the FSM allows solely
      // outside a pulse-to-completion window, so the core sees them stable.
      if (stash_key) begin
        pend_key_q    <= ikey;
        key_pending_q <= 1'b1;
      end

      if (accept) begin
        ocore_block  <= iin_data;
        ocore_encdec <= iin_encdec;
      end

      if (set_key_valid) begin
        okey_valid <= 1'b1;
      end

      // A timeout abandons everything, including a pending key; only a new
      // load restarts the sequencer.
      if (set_err) begin
        oerr          <= 1'b1;
        okey_valid    <= 1'b0;
        key_pending_q <= 1'b0;
      end

      if (block_done) begin
        oout_data  <= icore_block;
        oout_valid <= 1'b1;
        ocount     <= ocount + CNT_W'(1);
      end else if (oout_valid && iout_ready) begin
        oout_valid <= 1'b0;
      end
    end
  end

endmodule : klein_stream_ctrl

// File: tb/tb_klein_stream_ctrl.sv
// Directed bench for klein_stream_ctrl with a behavioural KLEIN core stand-in:
// ready drops one cycle after a pulse and returns 12 cycles later, and the
// result is block XOR key. Inputs change and outputs are sampled on the
// falling edge.
module tb_klein_stream_ctrl;

  localparam int CNT_W = 32;

  logic             iclk;
  logic             ireset_n;
  logic             ikey_load;
  logic [0:63]      ikey;
  logic             iin_valid;
  logic [0:63]      iin_data;
  logic             iin_encdec;
  logic             oin_ready;
  logic             oout_valid;
  logic [0:63]      oout_data;
  logic             iout_ready;
  logic             ocore_init;
  logic             ocore_next;
  logic             ocore_encdec;
  logic [0:63]      ocore_key;
  logic [0:63]      ocore_block;
  logic             icore_ready;
  logic             icore_result_valid;
  logic [0:63]      icore_block;
  logic             okey_valid;
  logic             oerr;
  logic [CNT_W-1:0] ocount;

  klein_stream_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_W         (CNT_W)
  ) dut (
    .iclk              (iclk),
    .ireset_n          (ireset_n),
    .ikey_load         (ikey_load),
    .ikey              (ikey),
    .iin_valid         (iin_valid),
    .iin_data          (iin_data),
    .iin_encdec        (iin_encdec),
    .oin_ready         (oin_ready),
    .oout_valid        (oout_valid),
    .oout_data         (oout_data),
    .iout_ready        (iout_ready),
    .ocore_init        (ocore_init),
    .ocore_next        (ocore_next),
    .ocore_encdec      (ocore_encdec),
    .ocore_key         (ocore_key),
    .ocore_block       (ocore_block),
    .icore_ready       (icore_ready),
    .icore_result_valid(icore_result_valid),
    .icore_block       (icore_block),
    .okey_valid        (okey_valid),
    .oerr              (oerr),
    .ocount            (ocount)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // ---------------- core stand-in ----------------
  logic       hang;      // never raise ready again
  int         rv_delay;  // cycles result_valid lags ready after a next
  int         mdl_cnt;
  int         mdl_rv_cnt;
  logic       mdl_is_next;

  always @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      icore_ready        <= 1'b1;
      icore_result_valid <= 1'b0;
      icore_block        <= '0;
      mdl_cnt            <= 0;
      mdl_rv_cnt         <= 0;
      mdl_is_next        <= 1'b0;
    end else if (ocore_init || ocore_next) begin
      icore_ready        <= 1'b0;
      icore_result_valid <= 1'b0;
      mdl_cnt            <= 12;
      mdl_rv_cnt         <= 0;
      mdl_is_next        <= ocore_next;
    end else begin
      if (mdl_cnt != 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1 && !hang) begin
          icore_ready <= 1'b1;
          if (mdl_is_next) begin
            if (rv_delay == 0) begin
              icore_result_valid <= 1'b1;
              icore_block        <= ocore_block ^ ocore_key;
            end else begin
              mdl_rv_cnt <= rv_delay;
            end
          end
        end
      end
      if (mdl_rv_cnt != 0) begin
        mdl_rv_cnt <= mdl_rv_cnt - 1;
        if (mdl_rv_cnt == 1) begin
          icore_result_valid <= 1'b1;
          icore_block        <= ocore_block ^ ocore_key;
        end
      end
    end
  end

  int n_init = 0;
  int n_next = 0;
  always @(posedge iclk) begin
    if (ocore_init) n_init <= n_init + 1;
    if (ocore_next) n_next <= n_next + 1;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return okey_valid;
      1:       return oout_valid;
      2:       return oerr;
      default: return 1'b0;
    endcase
  endfunction

  // Counts falling edges until the selected output is high, up to budget.
  task automatic wait_for(input int sel, input int budget, output int cyc);
    cyc = 0;
    while (!sig(sel) && cyc < budget) begin
      @(negedge iclk);
      cyc++;
    end
  endtask

  // Called on a falling edge; returns on the falling edge of the pulse cycle.
  task automatic load_key(input logic [63:0] k);
    ikey_load = 1'b1;
    ikey      = k;
    @(negedge iclk);
    ikey_load = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic send(input logic [63:0] d, input logic ed, output logic ok);
    iin_valid  = 1'b1;
    iin_data   = d;
    iin_encdec = ed;
    ok         = 1'b0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (oin_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge iclk);
    end
    @(negedge iclk);
    iin_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  localparam logic [63:0] K1   = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2   = 64'h1111111111111111;
  localparam logic [63:0] ALL1 = 64'hFFFFFFFFFFFFFFFF;

  logic        ok;
  logic        held_ok;
  int          cyc;
  int          base_init;
  int          base_next;
  logic [63:0] bp_blk [4];
  logic [63:0] bp_exp [4];

  initial begin
    bp_blk[0] = 64'h0000000000000000;  bp_exp[0] = 64'h0123456789ABCDEF;
    bp_blk[1] = 64'hFFFFFFFF00000000;  bp_exp[1] = 64'hFEDCBA9889ABCDEF;
    bp_blk[2] = 64'h0123456789ABCDEF;  bp_exp[2] = 64'h0000000000000000;
    bp_blk[3] = 64'hA5A5A5A5A5A5A5A5;  bp_exp[3] = 64'hA486E0C22C0E684A;

    ireset_n   = 1'b0;
    ikey_load  = 1'b0;
    ikey       = '0;
    iin_valid  = 1'b0;
    iin_data   = '0;
    iin_encdec = 1'b0;
    iout_ready = 1'b1;
    hang       = 1'b0;
    rv_delay   = 0;
    repeat (3) @(negedge iclk);
    ireset_n = 1'b1;
    @(negedge iclk);

    // Reset values
    check("rst_in_ready",   64'(oin_ready),    64'd0);
    check("rst_out_valid",  64'(oout_valid),   64'd0);
    check("rst_out_data",   64'(oout_data),    64'd0);
    check("rst_init",       64'(ocore_init),   64'd0);
    check("rst_next",       64'(ocore_next),   64'd0);
    check("rst_encdec",     64'(ocore_encdec), 64'd1);
    check("rst_core_key",   64'(ocore_key),    64'd0);
    check("rst_core_block", 64'(ocore_block),  64'd0);
    check("rst_key_valid",  64'(okey_valid),   64'd0);
    check("rst_err",        64'(oerr),         64'd0);
    check("rst_count",      64'(ocount),       64'd0);

    // No key: input stays blocked
    iin_valid = 1'b1;
    iin_data  = 64'hDEADBEEFDEADBEEF;
    repeat (3) begin
      @(negedge iclk);
      #1;
      check("nokey_in_ready", 64'(oin_ready), 64'd0);
    end
    iin_valid = 1'b0;
    check("nokey_no_pulses", 64'(n_init + n_next), 64'd0);
    @(negedge iclk);

    // Key then encrypt
    load_key(K1);
    check("init_pulse", 64'(ocore_init), 64'd1);
    check("init_key",   64'(ocore_key),  K1);
    wait_for(0, 40, cyc);
    check("init_latency", 64'(cyc), 64'd14);
    send(ALL1, 1'b1, ok);
    check("enc_accept",   64'(ok),           64'd1);
    check("enc_next",     64'(ocore_next),   64'd1);
    check("enc_encdec",   64'(ocore_encdec), 64'd1);
    check("enc_block",    64'(ocore_block),  ALL1);
    wait_for(1, 40, cyc);
    check("enc_latency",  64'(cyc),          64'd14);
    check("enc_result",   64'(oout_data),    64'hFEDCBA9876543210);
    check("enc_count",    64'(ocount),       64'd1);
    check("enc_one_init", 64'(n_init),       64'd1);
    check("enc_one_next", 64'(n_next),       64'd1);
    @(negedge iclk);
    check("enc_drained",  64'(oout_valid),   64'd0);

    // Asynchronous reset during NEXT_WAIT
    send(64'h0, 1'b1, ok);
    repeat (4) @(negedge iclk);
    check("pre_rst_count", 64'(ocount), 64'd1);
    #2 ireset_n = 1'b0;
    #1;
    check("arst_count",     64'(ocount),       64'd0);
    check("arst_out_data",  64'(oout_data),    64'd0);
    check("arst_core_key",  64'(ocore_key),    64'd0);
    check("arst_block",     64'(ocore_block),  64'd0);
    check("arst_next",      64'(ocore_next),   64'd0);
    check("arst_key_valid", 64'(okey_valid),   64'd0);
    check("arst_encdec",    64'(ocore_encdec), 64'd1);
    @(negedge iclk);
    ireset_n  = 1'b1;
    iin_valid = 1'b1;
    @(negedge iclk);
    #1;
    check("arst_in_ready", 64'(oin_ready), 64'd0);
    iin_valid = 1'b0;

    // Backpressure with four blocks
    load_key(K1);
    check("bp_init", 64'(ocore_init), 64'd1);
    wait_for(0, 40, cyc);
    check("bp_key_ready", 64'(okey_valid), 64'd1);
    base_next  = n_next;
    iout_ready = 1'b0;
    send(bp_blk[0], 1'b1, ok);
    check("bp_accept0", 64'(ok), 64'd1);
    iin_valid  = 1'b1;
    iin_data   = bp_blk[1];
    iin_encdec = 1'b1;
    wait_for(1, 40, cyc);
    check("bp_result0", 64'(oout_data), bp_exp[0]);
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      #1;
      check("bp_hold_ready", 64'(oin_ready),  64'd0);
      check("bp_hold_valid", 64'(oout_valid), 64'd1);
      check("bp_hold_data",  64'(oout_data),  bp_exp[0]);
    end
    check("bp_one_issued", 64'(n_next - base_next), 64'd1);
    iout_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      send(bp_blk[i], 1'b1, ok);
      check("bp_accept", 64'(ok), 64'd1);
      wait_for(1, 40, cyc);
      check("bp_result", 64'(oout_data), bp_exp[i]);
    end
    check("bp_count",      64'(ocount),             64'd4);
    check("bp_four_nexts", 64'(n_next - base_next), 64'd4);

    // Key change during NEXT_WAIT
    base_init = n_init;
    send(ALL1, 1'b1, ok);
    repeat (3) @(negedge iclk);
    load_key(K2);
    check("kc_key_stable", 64'(ocore_key), K1);
    wait_for(1, 40, cyc);
    check("kc_old_key_result", 64'(oout_data), 64'hFEDCBA9876543210);
    #1;
    check("kc_input_blocked", 64'(oin_ready), 64'd0);
    @(negedge iclk);
    check("kc_init",      64'(ocore_init), 64'd1);
    check("kc_new_key",   64'(ocore_key),  K2);
    check("kc_key_inval", 64'(okey_valid), 64'd0);
    wait_for(0, 40, cyc);
    check("kc_init_latency", 64'(cyc), 64'd14);
    check("kc_one_init", 64'(n_init - base_init), 64'd1);
    send(64'h0, 1'b1, ok);
    wait_for(1, 40, cyc);
    check("kc_new_key_result", 64'(oout_data), K2);

    // Decipher direction, result_valid one cycle after ready
    rv_delay = 1;
    send(64'h0123456789ABCDEF, 1'b0, ok);
    check("dec_next",   64'(ocore_next),   64'd1);
    check("dec_encdec", 64'(ocore_encdec), 64'd0);
    held_ok = 1'b1;
    cyc     = 0;
    while (!oout_valid && cyc < 40) begin
      @(negedge iclk);
      cyc++;
      if (ocore_encdec !== 1'b0 || ocore_block !== 64'h0123456789ABCDEF ||
          ocore_key !== K2)
        held_ok = 1'b0;
    end
    check("dec_operands_held", 64'(held_ok),   64'd1);
    check("dec_latency",       64'(cyc),       64'd15);
    check("dec_result",        64'(oout_data), 64'h1032547698BADCFE);
    rv_delay = 0;
    @(negedge iclk);

    // Timeout: core never returns ready
    hang = 1'b1;
    send(64'h5555555555555555, 1'b1, ok);
    check("to_next", 64'(ocore_next), 64'd1);
    wait_for(2, 40, cyc);
    check("to_latency",   64'(cyc),        64'd16);
    check("to_err",       64'(oerr),       64'd1);
    check("to_key_inval", 64'(okey_valid), 64'd0);
    check("to_no_output", 64'(oout_valid), 64'd0);
    iin_valid = 1'b1;
    repeat (5) @(negedge iclk);
    #1;
    check("to_in_blocked", 64'(oin_ready),  64'd0);
    check("to_still_none", 64'(oout_valid), 64'd0);
    check("to_err_sticky", 64'(oerr),       64'd1);
    iin_valid = 1'b0;
    hang      = 1'b0;
    @(negedge iclk);
    load_key(K1);
    check("rec_init",      64'(ocore_init), 64'd1);
    check("rec_err_clear", 64'(oerr),       64'd0);
    check("rec_count_clr", 64'(ocount),     64'd0);
    wait_for(0, 40, cyc);
    check("rec_key_valid", 64'(okey_valid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_klein_stream_ctrl
